// File: rtl/dram_arbiter_if.sv
// Request/response and DRAM command bundle between dram_arbiter (slave) and its requesters (master).
interface dram_arbiter_if #(
    parameter int unsigned ADDR_W = 27,
    parameter int unsigned DATA_W = 128,
    parameter int unsigned MASK_W = 16
);
    logic              m0_req_valid;
    logic              m0_req_ready;
    logic              m0_req_wen;
    logic [ADDR_W-1:0] m0_req_addr;
    logic [DATA_W-1:0] m0_req_wdata;
    logic [MASK_W-1:0] m0_req_wmask;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_rvalid;

    logic              m1_req_valid;
    logic              m1_req_ready;
    logic              m1_req_wen;
    logic [ADDR_W-1:0] m1_req_addr;
    logic [DATA_W-1:0] m1_req_wdata;
    logic [MASK_W-1:0] m1_req_wmask;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_rvalid;

    logic              dram_ren;
    logic              dram_wen;
    logic [ADDR_W-1:0] dram_addr;
    logic [DATA_W-1:0] dram_wdata;
    logic [MASK_W-1:0] dram_wmask;
    logic              dram_init_calib_complete;
    logic              dram_busy;
    logic [DATA_W-1:0] dram_rdata;
    logic              dram_rdata_valid;

    logic              err_timeout;
    logic              err_spurious;

    modport slave (
        input  m0_req_valid, m0_req_wen, m0_req_addr, m0_req_wdata, m0_req_wmask,
        input  m1_req_valid, m1_req_wen, m1_req_addr, m1_req_wdata, m1_req_wmask,
        input  dram_init_calib_complete, dram_busy, dram_rdata, dram_rdata_valid,
        output m0_req_ready, m0_rdata, m0_rvalid,
        output m1_req_ready, m1_rdata, m1_rvalid,
        output dram_ren, dram_wen, dram_addr, dram_wdata, dram_wmask,
        output err_timeout, err_spurious
    );

    modport master (
        output m0_req_valid, m0_req_wen, m0_req_addr, m0_req_wdata, m0_req_wmask,
        output m1_req_valid, m1_req_wen, m1_req_addr, m1_req_wdata, m1_req_wmask,
        output dram_init_calib_complete, dram_busy, dram_rdata, dram_rdata_valid,
        input  m0_req_ready, m0_rdata, m0_rvalid,
        input  m1_req_ready, m1_rdata, m1_rvalid,
        input  dram_ren, dram_wen, dram_addr, dram_wdata, dram_wmask,
        input  err_timeout, err_spurious
    );
endinterface

// File: rtl/dram_arbiter.sv
// Two-port DRAM request arbiter/sequencer with read routing and read watchdog.
// Define DRAM_ARB_RR_EN for round-robin arbitration; default is fixed priority (port 0 wins).
module dram_arbiter #(
    parameter int unsigned ADDR_W     = 27,
    parameter int unsigned DATA_W     = 128,
    parameter int unsigned MASK_W     = 16,
    parameter int unsigned RD_TIMEOUT = 1023
) (
    input  logic          clk_166_67_mhz,
    input  logic          dram_rstx_async,
    dram_arbiter_if.slave bus
);
    localparam int unsigned WD_RAW = $clog2(RD_TIMEOUT + 1);
    localparam int unsigned WD_W   = (WD_RAW < 10) ? 10 : WD_RAW;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(RD_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

    state_t state, state_nxt;

    logic              gnt0_c, gnt1_c, grant_c;
    logic              cmd_taken_c, rd_done_c, rd_tmo_c;
    logic              sel_wen_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] sel_wdata_c;
    logic [MASK_W-1:0] sel_wmask_c;
    logic [DATA_W-1:0] ret_data_c;

    logic              wen_q, owner_q;
    logic              ren_stb_q, wen_stb_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic              rvalid0_q, rvalid1_q;
    logic              err_tmo_q, err_spur_q;
    logic [WD_W-1:0]   wd_q;
`ifdef DRAM_ARB_RR_EN
    logic              last_grant_q;
`endif

    // State register
    always_ff @(posedge clk_166_67_mhz or negedge dram_rstx_async) begin
        if (!dram_rstx_async) state <= IDLE;
        else                  state <= state_nxt;
    end

    // Arbitration, command acceptance and read completion
    always_comb begin
        state_nxt   = state;
        gnt0_c      = 1'b0;
        gnt1_c      = 1'b0;
        cmd_taken_c = 1'b0;
        rd_done_c   = 1'b0;
        rd_tmo_c    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.dram_init_calib_complete && dram_rstx_async) begin
`ifdef DRAM_ARB_RR_EN
                    if (bus.m0_req_valid && bus.m1_req_valid) begin
                        gnt0_c = last_grant_q;
                        gnt1_c = !last_grant_q;
                    end else begin
                        gnt0_c = bus.m0_req_valid;
                        gnt1_c = bus.m1_req_valid;
                    end
`else
                    gnt0_c = bus.m0_req_valid;
                    gnt1_c = bus.m1_req_valid && !bus.m0_req_valid;
`endif
                end
                if (gnt0_c || gnt1_c) state_nxt = ISSUE;
            end
            ISSUE: begin
                // The strobe is always up in ISSUE, so acceptance is just !busy
                if (!bus.dram_busy) begin
                    cmd_taken_c = 1'b1;
                    state_nxt   = wen_q ? IDLE : WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (bus.dram_rdata_valid) begin
                    rd_done_c = 1'b1;
                    state_nxt = IDLE;
                end else if (wd_q == WD_LAST) begin
                    rd_tmo_c  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign grant_c     = gnt0_c || gnt1_c;
    assign sel_wen_c   = gnt1_c ? bus.m1_req_wen   : bus.m0_req_wen;
    assign sel_addr_c  = gnt1_c ? bus.m1_req_addr  : bus.m0_req_addr;
    assign sel_wdata_c = gnt1_c ? bus.m1_req_wdata : bus.m0_req_wdata;
    assign sel_wmask_c = gnt1_c ? bus.m1_req_wmask : bus.m0_req_wmask;
    assign ret_data_c  = rd_done_c ? bus.dram_rdata : '0;

    // Request latch, command strobes, watchdog, read return and error flags
    always_ff @(posedge clk_166_67_mhz or negedge dram_rstx_async) begin
        if (!dram_rstx_async) begin
            wen_q        <= 1'b0;
            owner_q      <= 1'b0;
            ren_stb_q    <= 1'b0;
            wen_stb_q    <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            rvalid0_q    <= 1'b0;
            rvalid1_q    <= 1'b0;
            err_tmo_q    <= 1'b0;
            err_spur_q   <= 1'b0;
            wd_q         <= '0;
`ifdef DRAM_ARB_RR_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            if (grant_c) begin
                wen_q     <= sel_wen_c;
                owner_q   <= gnt1_c;
                addr_q    <= sel_addr_c;
                wdata_q   <= sel_wdata_c;
                wmask_q   <= sel_wmask_c;
                ren_stb_q <= !sel_wen_c;
                wen_stb_q <= sel_wen_c;
`ifdef DRAM_ARB_RR_EN
                last_grant_q <= gnt1_c;
`endif
            end
            if (cmd_taken_c) begin
                ren_stb_q <= 1'b0;
                wen_stb_q <= 1'b0;
                wd_q      <= '0;
            end
            if (state == WAIT_RD && !rd_done_c && !rd_tmo_c) wd_q <= wd_q + WD_W'(1);
            // Timeout returns zero data so the owner is never left waiting
            if (rd_done_c || rd_tmo_c) begin
                if (owner_q) begin
                    rdata1_q  <= ret_data_c;
                    rvalid1_q <= 1'b1;
                end else begin
                    rdata0_q  <= ret_data_c;
                    rvalid0_q <= 1'b1;
                end
            end
            if (rd_tmo_c) err_tmo_q <= 1'b1;
            if (bus.dram_rdata_valid && state != WAIT_RD) err_spur_q <= 1'b1;
        end
    end

    assign bus.m0_req_ready = gnt0_c;
    assign bus.m1_req_ready = gnt1_c;
    assign bus.m0_rdata     = rdata0_q;
    assign bus.m1_rdata     = rdata1_q;
    assign bus.m0_rvalid    = rvalid0_q;
    assign bus.m1_rvalid    = rvalid1_q;
    assign bus.dram_ren     = ren_stb_q;
    assign bus.dram_wen     = wen_stb_q;
    assign bus.dram_addr    = addr_q;
    assign bus.dram_wdata   = wdata_q;
    assign bus.dram_wmask   = wmask_q;
    assign bus.err_timeout  = err_tmo_q;
    assign bus.err_spurious = err_spur_q;
endmodule

// File: tb/tb_dram_arbiter.sv
// Directed self-checking bench for dram_arbiter: calibration gating, routing, backpressure,
// arbitration order, watchdog, reset and spurious read data.
module tb_dram_arbiter;
    localparam int unsigned ADDR_W     = 27;
    localparam int unsigned DATA_W     = 128;
    localparam int unsigned MASK_W     = 16;
    localparam int unsigned RD_TIMEOUT = 1023;

    logic        clk_166_67_mhz = 1'b0;
    logic        dram_rstx_async;
    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    int unsigned cyc_n   = 0;

    dram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) bus ();

    dram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .RD_TIMEOUT(RD_TIMEOUT)
    ) dut (
        .clk_166_67_mhz (clk_166_67_mhz),
        .dram_rstx_async(dram_rstx_async),
        .bus            (bus)
    );

    always #3 clk_166_67_mhz = ~clk_166_67_mhz;
    always @(posedge clk_166_67_mhz) cyc_n <= cyc_n + 1;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_166_67_mhz);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_166_67_mhz);
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_flags"}, 128'({bus.m0_req_ready, bus.m1_req_ready, bus.m0_rvalid, bus.m1_rvalid,
                                        bus.dram_ren, bus.dram_wen, bus.err_timeout, bus.err_spurious}), 128'd0);
        check_eq({pfx, "_addr"},   128'(bus.dram_addr),  128'd0);
        check_eq({pfx, "_wdata"},  128'(bus.dram_wdata), 128'd0);
        check_eq({pfx, "_wmask"},  128'(bus.dram_wmask), 128'd0);
        check_eq({pfx, "_m0data"}, 128'(bus.m0_rdata),   128'd0);
        check_eq({pfx, "_m1data"}, 128'(bus.m1_rdata),   128'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [127:0] d_cal, d_rt, d_bp;
        logic [127:0] wd_bp;
        logic         bad_flag, stable, no_rdy;
        int unsigned  t0, lat, g;
        logic [3:0]   grants, exp_grants;
        logic         onehot_bad;

        d_cal = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        d_rt  = 128'hDEAD_C0DE_0123_4567_89AB_CDEF_5A5A_BEEF;
        d_bp  = 128'hCAFE_F00D_0000_FFFF_1234_5678_9ABC_DEF0;
        wd_bp = 128'hA5A5_A5A5_5A5A_5A5A_0F0F_0F0F_F0F0_F0F0;

        dram_rstx_async              = 1'b0;
        bus.m0_req_valid             = 1'b0;
        bus.m0_req_wen               = 1'b0;
        bus.m0_req_addr              = '0;
        bus.m0_req_wdata             = '0;
        bus.m0_req_wmask             = '0;
        bus.m1_req_valid             = 1'b0;
        bus.m1_req_wen               = 1'b0;
        bus.m1_req_addr              = '0;
        bus.m1_req_wdata             = '0;
        bus.m1_req_wmask             = '0;
        bus.dram_init_calib_complete = 1'b0;
        bus.dram_busy                = 1'b0;
        bus.dram_rdata               = '0;
        bus.dram_rdata_valid         = 1'b0;

        // Reset state
        repeat (3) cyc();
        smp();
        check_all_zero("por");
        cyc();
        dram_rstx_async = 1'b1;

        // Calibration gating: no grant or strobe while calib is low
        cyc();
        bus.m0_req_valid = 1'b1;
        bus.m0_req_addr  = 27'h0000010;
        bad_flag = 1'b0;
        for (int i = 0; i < 20; i++) begin
            smp();
            bad_flag = bad_flag | bus.m0_req_ready | bus.m1_req_ready | bus.dram_ren | bus.dram_wen;
            cyc();
        end
        check_eq("calib_hold", 128'(bad_flag), 128'd0);
        bus.dram_init_calib_complete = 1'b1;
        smp();
        check_eq("calib_ready", 128'(bus.m0_req_ready), 128'd1);
        cyc();
        bus.m0_req_valid = 1'b0;
        smp();
        check_eq("calib_ren", 128'({bus.dram_ren, bus.dram_wen}), 128'b10);
        check_eq("calib_addr", 128'(bus.dram_addr), 128'h10);
        cyc();
        bus.dram_rdata_valid = 1'b1;
        bus.dram_rdata       = d_cal;
        cyc();
        bus.dram_rdata_valid = 1'b0;
        smp();
        check_eq("calib_rvalid", 128'({bus.m0_rvalid, bus.m1_rvalid}), 128'b10);
        check_eq("calib_rdata", bus.m0_rdata, d_cal);

        // Read routing to port 1
        cyc();
        bus.m1_req_valid = 1'b1;
        bus.m1_req_wen   = 1'b0;
        bus.m1_req_addr  = 27'h0001234;
        smp();
        check_eq("rt_ready", 128'({bus.m0_req_ready, bus.m1_req_ready}), 128'b01);
        cyc();
        bus.m1_req_valid = 1'b0;
        smp();
        check_eq("rt_cmd", 128'({bus.dram_ren, bus.dram_wen}), 128'b10);
        check_eq("rt_addr", 128'(bus.dram_addr), 128'h1234);
        repeat (5) cyc();
        bus.dram_rdata_valid = 1'b1;
        bus.dram_rdata       = d_rt;
        cyc();
        bus.dram_rdata_valid = 1'b0;
        bus.dram_rdata       = '0;
        smp();
        check_eq("rt_rvalid", 128'({bus.m0_rvalid, bus.m1_rvalid}), 128'b01);
        check_eq("rt_rdata", bus.m1_rdata, d_rt);
        cyc();
        smp();
        check_eq("rt_pulse", 128'({bus.m0_rvalid, bus.m1_rvalid}), 128'b00);
        check_eq("rt_hold", bus.m1_rdata, d_rt);

        // Backpressure: m0 write stalled 7 cycles, m1 read waits behind it
        cyc();
        bus.dram_busy    = 1'b1;
        bus.m0_req_valid = 1'b1;
        bus.m0_req_wen   = 1'b1;
        bus.m0_req_addr  = 27'h7FFFFFF;
        bus.m0_req_wdata = wd_bp;
        bus.m0_req_wmask = 16'hA5F0;
        bus.m1_req_valid = 1'b1;
        bus.m1_req_wen   = 1'b0;
        bus.m1_req_addr  = 27'h0000055;
        smp();
        check_eq("bp_ready", 128'({bus.m0_req_ready, bus.m1_req_ready}), 128'b10);
        cyc();
        bus.m0_req_valid = 1'b0;
        stable = 1'b1;
        no_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            smp();
            if (!(bus.dram_wen === 1'b1 && bus.dram_ren === 1'b0 && bus.dram_addr === 27'h7FFFFFF &&
                  bus.dram_wdata === wd_bp && bus.dram_wmask === 16'hA5F0)) stable = 1'b0;
            if (bus.m0_req_ready !== 1'b0 || bus.m1_req_ready !== 1'b0) no_rdy = 1'b0;
            cyc();
            if (i == 6) bus.dram_busy = 1'b0;
        end
        check_eq("bp_stable", 128'(stable), 128'd1);
        check_eq("bp_no_ready", 128'(no_rdy), 128'd1);
        smp();
        check_eq("bp_wen_done", 128'(bus.dram_wen), 128'd0);
        check_eq("bp_m1_ready", 128'(bus.m1_req_ready), 128'd1);
        cyc();
        bus.m1_req_valid = 1'b0;
        smp();
        check_eq("bp_ren", 128'({bus.dram_ren, bus.dram_wen}), 128'b10);
        check_eq("bp_raddr", 128'(bus.dram_addr), 128'h55);
        cyc();
        bus.dram_rdata_valid = 1'b1;
        bus.dram_rdata       = d_bp;
        cyc();
        bus.dram_rdata_valid = 1'b0;
        smp();
        check_eq("bp_rdata", bus.m1_rdata, d_bp);
        check_eq("bp_m0_hold", bus.m0_rdata, d_cal);

        // Watchdog: read with no return
        cyc();
        bus.m0_req_valid = 1'b1;
        bus.m0_req_wen   = 1'b0;
        bus.m0_req_addr  = 27'h0000000;
        smp();
        check_eq("wd_ready", 128'(bus.m0_req_ready), 128'd1);
        t0 = cyc_n;
        cyc();
        bus.m0_req_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 1100; i++) begin
            smp();
            if (bus.m0_rvalid === 1'b1) begin
                lat = cyc_n - t0;
                break;
            end
            cyc();
        end
        check_eq("wd_latency", 128'(lat), 128'd1025);
        check_eq("wd_rdata", bus.m0_rdata, 128'd0);
        check_eq("wd_m1_rvalid", 128'(bus.m1_rvalid), 128'd0);
        check_eq("wd_err", 128'(bus.err_timeout), 128'd1);
        repeat (4) cyc();
        smp();
        check_eq("wd_sticky", 128'({bus.err_timeout, bus.m0_rvalid}), 128'b10);

        // Reset during WAIT_RD, then a late return in IDLE is spurious
        cyc();
        bus.m1_req_valid = 1'b1;
        bus.m1_req_addr  = 27'h2AAAAAA;
        smp();
        check_eq("rs_ready", 128'(bus.m1_req_ready), 128'd1);
        cyc();
        bus.m1_req_valid = 1'b0;
        repeat (2) cyc();
        dram_rstx_async = 1'b0;
        smp();
        check_all_zero("mid");
        cyc();
        dram_rstx_async      = 1'b1;
        bus.dram_rdata_valid = 1'b1;
        bus.dram_rdata       = d_rt;
        cyc();
        bus.dram_rdata_valid = 1'b0;
        smp();
        check_eq("sp_err", 128'(bus.err_spurious), 128'd1);
        check_eq("sp_rvalid", 128'({bus.m0_rvalid, bus.m1_rvalid, bus.dram_ren}), 128'd0);
        check_eq("sp_rdata", bus.m1_rdata, 128'd0);

        // Simultaneous writes from both ports, four grants
        cyc();
        bus.m0_req_valid = 1'b1;
        bus.m0_req_wen   = 1'b1;
        bus.m0_req_addr  = 27'h0000100;
        bus.m1_req_valid = 1'b1;
        bus.m1_req_wen   = 1'b1;
        bus.m1_req_addr  = 27'h0000200;
        g          = 0;
        grants     = 4'b0000;
        onehot_bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (g >= 4) break;
            smp();
            if (bus.m0_req_ready === 1'b1 || bus.m1_req_ready === 1'b1) begin
                if (bus.m0_req_ready === 1'b1 && bus.m1_req_ready === 1'b1) onehot_bad = 1'b1;
                grants[g] = bus.m1_req_ready;
                g++;
            end
            cyc();
        end
        bus.m0_req_valid = 1'b0;
        bus.m1_req_valid = 1'b0;
`ifdef DRAM_ARB_RR_EN
        exp_grants = 4'b1010;
`else
        exp_grants = 4'b0000;
`endif
        check_eq("arb_count", 128'(g), 128'd4);
        check_eq("arb_order", 128'(grants), 128'(exp_grants));
        check_eq("arb_onehot", 128'(onehot_bad), 128'd0);

        repeat (3) cyc();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Two-port arbiter and command sequencer in front of the DRAM controller's user-side request interface. Two requesters share the single DRAM command/data path: port 0 is instruction fetch/cache refill and port 1 is data load/store. The block holds requests until DRAM calibration completes, grants one request at a time, and issues it while respecting DRAM backpressure. It routes read data back to the owning port and guards each read with a watchdog.

## Interface
Parameters:
- ADDR_W, 27, DRAM user address width.
- DATA_W, 128, DRAM data word width.
- MASK_W, 16, byte-mask width (DATA_W/8).
- RD_TIMEOUT, 1023, cycles to wait for read data before the watchdog fires (10-bit counter minimum).

Ports (N ∈ {0,1}; each listed line exists once per port):
- clk_166_67_mhz  in  1  block clock.
- dram_rstx_async  in  1  reset: asynchronous assert, active-low.
- mN_req_valid  in  1  request pending; held stable until accepted.
- mN_req_ready  out  1  request accepted this cycle.
- mN_req_wen  in  1  1 = write, 0 = read.
- mN_req_addr  in  ADDR_W  word address.
- mN_req_wdata  in  DATA_W  write data.
- mN_req_wmask  in  MASK_W  byte mask, passed unmodified (1 = byte not written).
- mN_rdata  out  DATA_W  read data.
- mN_rvalid  out  1  one-cycle pulse; mN_rdata valid.
- dram_ren / dram_wen  out  1  read / write command strobe.
- dram_addr  out  ADDR_W; dram_wdata  out  DATA_W; dram_wmask  out  MASK_W.
- dram_init_calib_complete  in  1  DRAM usable.
- dram_busy  in  1  command not accepted this cycle.
- dram_rdata  in  DATA_W; dram_rdata_valid  in  1  read return.
- err_timeout  out  1  sticky: read watchdog fired.
- err_spurious  out  1  sticky: dram_rdata_valid seen outside WAIT_RD.

## Operation
- States: IDLE, ISSUE, WAIT_RD.
- IDLE:
  - Requests are considered only while dram_init_calib_complete=1.
  - On a grant, assert winner's mN_req_ready combinationally.
  - Latch wen, addr, wdata, wmask and owner. Go to ISSUE.
- ISSUE:
  - Drive dram_ren (read) or dram_wen (write) from latched registers.
  - The command is taken on the first cycle with strobe=1 and dram_busy=0.
  - After a taken write, go to IDLE. After a taken read, clear the watchdog and go to WAIT_RD.
  - Strobe and payload stay stable while busy.
- WAIT_RD:
  - On dram_rdata_valid, register dram_rdata to the owner's mN_rdata and pulse owner's mN_rvalid next cycle. Go to IDLE.
  - Watchdog increments each cycle. On reaching RD_TIMEOUT: pulse owner rvalid with rdata=0, set err_timeout, go to IDLE.
- mN_rdata holds its last value between pulses. The non-owner's rvalid stays 0.
- dram_rdata_valid in IDLE/ISSUE: ignored, sets err_spurious.
- Calibration dropping mid-transaction does not abort; it only blocks new grants.
- Reset (asynchronous, any state):
  - State returns to IDLE.
  - All outputs clear to 0, including rdata and both error flags.
  - last_grant is set to 1.
  - An in-flight command is abandoned with no rvalid.

## Timing
- Accept at cycle t. Strobe is first high at t+1.
- Minimum read: rdata_valid at t+1+k gives rvalid at t+2+k.
- Write throughput: one per 2 cycles with no busy. Read throughput: one outstanding read.
- mN_req_ready is never asserted in ISSUE or WAIT_RD.
- Only one ready is asserted per cycle.

## Configuration
- DRAM_ARB_RR_EN defined: round-robin arbitration. On simultaneous valid, the port not equal to last_grant wins; last_grant updates on each grant.
- DRAM_ARB_RR_EN undefined: fixed priority, port 0 always wins; last_grant is unused.

## Test plan
- Calibration gating: m0 read valid with calib=0 for 20 cycles -> no ready, no strobe. Calib=1 -> ready at next cycle, dram_ren the cycle after.
- Read routing: m1 read addr=0x0001234, rdata_valid after 5 cycles with 0xDEAD…BEEF -> m1_rvalid 1 cycle, m1_rdata matches, m0_rvalid=0.
- Backpressure: m0 write with dram_busy=1 for 7 cycles -> dram_wen, addr, wdata, wmask stable for 8 cycles, then IDLE.
- Simultaneous requests: both valid for 4 transactions -> RR build grants 0,1,0,1; non-RR build grants 0,0,0,0.
- Watchdog: read with no rdata_valid -> after 1023 WAIT_RD cycles owner rvalid with rdata=0, err_timeout=1, sticky until reset.
- Reset and spurious: dram_rstx_async low during WAIT_RD -> all outputs 0, state IDLE. A stray dram_rdata_valid in IDLE -> err_spurious=1, no rvalid.
